// File: rtl/serial_xfer_scheduler.sv
// Sequences the full-duplex serial engine for a TX and an RX client: round-robin grant,
// timed start pulse, busy/idle tracking, ack/data return and a sticky timeout error.
module serial_xfer_scheduler #(
  parameter int DATA_WIDTH_BASE = 5,
  parameter int START_HOLD      = 2,
  parameter int TIMEOUT         = 1023,
  localparam int W              = 2 ** DATA_WIDTH_BASE
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tx_req_i,
  input  logic [W-1:0] tx_wdata_i,
  output logic         tx_ack_o,
  input  logic         rx_req_i,
  output logic         rx_ack_o,
  output logic [W-1:0] rx_rdata_o,
  output logic         err_o,
  input  logic         err_clr_i,
  output logic         last_mode_o,
  output logic         eng_start_o,
  output logic         eng_mode_o,
  output logic [W-1:0] eng_transmit_data_o,
  input  logic         eng_busy_i,
  input  logic         eng_finish_i,
  input  logic [W-1:0] eng_receive_data_i,
  output logic [7:0]   finish_cnt_o
);

  localparam int HCW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(START_HOLD - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_RUN, S_DONE, S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           rr_rx_q, rr_rx_d;
  logic           mode_q, mode_d;
  logic [W-1:0]   txd_q, txd_d;
  logic [W-1:0]   rdata_q, rdata_d;
  logic [7:0]     fcnt_q, fcnt_d;
  logic           err_q, err_d;
  logic           tx_ack_q, tx_ack_d;
  logic           rx_ack_q, rx_ack_d;
  logic           grant_rx, to_err, to_done;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    tmo_d    = tmo_q;
    rr_rx_d  = rr_rx_q;
    mode_d   = mode_q;
    txd_d    = txd_q;
    rdata_d  = rdata_q;
    fcnt_d   = fcnt_q;
    err_d    = err_q;
    tx_ack_d = 1'b0;
    rx_ack_d = 1'b0;
    grant_rx = 1'b0;
    to_err   = 1'b0;
    to_done  = 1'b0;
    if (err_clr_i) err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_req_i || rx_req_i) begin
          // Pointer only moves on contention; a lone requester never steals the other's turn.
          grant_rx = rx_req_i && (!tx_req_i || rr_rx_q);
          if (tx_req_i && rx_req_i) rr_rx_d = ~rr_rx_q;
          mode_d = grant_rx;
          if (!grant_rx) txd_d = tx_wdata_i;
          fcnt_d  = '0;
          hold_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hold_q == HOLD_LAST) begin
          tmo_d   = '0;
          state_d = S_WAIT_BUSY;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      S_WAIT_BUSY: begin
        if (eng_busy_i) begin
          tmo_d   = '0;
          state_d = S_RUN;
        end else if (tmo_q == TMO_LAST) begin
          to_err = 1'b1;
        end else begin
          tmo_d = tmo_q + TCW'(1);
        end
      end
      S_RUN: begin
        if (eng_finish_i && fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
        if (!eng_busy_i) to_done = 1'b1;
        else if (tmo_q == TMO_LAST) to_err = 1'b1;
        else tmo_d = tmo_q + TCW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   if (err_clr_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Acks are registered on entry so they land in the DONE / first ERR cycle together with rx data.
    if (to_done) begin
      state_d  = S_DONE;
      tx_ack_d = ~mode_q;
      rx_ack_d = mode_q;
      if (mode_q) rdata_d = eng_receive_data_i;
    end
    if (to_err) begin
      state_d  = S_ERR;
      err_d    = 1'b1;
      tx_ack_d = ~mode_q;
      rx_ack_d = mode_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      tmo_q    <= '0;
      rr_rx_q  <= 1'b1;
      mode_q   <= 1'b0;
      txd_q    <= '0;
      rdata_q  <= '0;
      fcnt_q   <= '0;
      err_q    <= 1'b0;
      tx_ack_q <= 1'b0;
      rx_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      tmo_q    <= tmo_d;
      rr_rx_q  <= rr_rx_d;
      mode_q   <= mode_d;
      txd_q    <= txd_d;
      rdata_q  <= rdata_d;
      fcnt_q   <= fcnt_d;
      err_q    <= err_d;
      tx_ack_q <= tx_ack_d;
      rx_ack_q <= rx_ack_d;
    end
  end

  assign eng_start_o         = (state_q == S_ISSUE);
  assign eng_mode_o          = (state_q == S_ISSUE) && mode_q;
  assign eng_transmit_data_o = txd_q;
  assign tx_ack_o            = tx_ack_q;
  assign rx_ack_o            = rx_ack_q;
  assign rx_rdata_o          = rdata_q;
  assign err_o               = err_q;
  assign last_mode_o         = mode_q;
  assign finish_cnt_o        = fcnt_q;

endmodule

// File: doc/serial_xfer_scheduler.md
Name: serial_xfer_scheduler

Overview:
- Sequences the full-duplex serial engine (start/mode/busy/finish interface) on behalf of two requesters: a TX client and an RX client.
- Arbitrates round-robin between pending requests and issues the start pulse with the correct mode.
- Waits for the engine to go busy and then idle, returns RX data or a TX acknowledge, and reports a timeout if the engine stalls.
- Sits between system logic and the engine top level; it is the only driver of the engine's start, mode and transmit_data inputs.

Parameters:
- DATA_WIDTH_BASE, 5, word width is 2**DATA_WIDTH_BASE bits (W).
- START_HOLD, 2, number of clk cycles eng_start/eng_mode are held asserted (minimum 1).
- TIMEOUT, 1023, maximum clk cycles allowed in WAIT_BUSY or RUN before the error path is taken.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- tx_req  in  1  TX client request, level; held until tx_ack.
- tx_wdata  in  W  word to transmit; sampled when the TX grant is taken.
- tx_ack  out  1  one-cycle pulse when the TX transfer completes or errors.
- rx_req  in  1  RX client request, level; held until rx_ack.
- rx_ack  out  1  one-cycle pulse when the RX transfer completes or errors.
- rx_rdata  out  W  received word; valid in the rx_ack cycle and held until the next RX completion.
- err  out  1  sticky timeout flag; cleared by err_clr or rst.
- err_clr  in  1  clears err; also releases the ERR state.
- last_mode  out  1  mode of the last granted transfer (1 = RX, 0 = TX).
- eng_start  out  1  engine start.
- eng_mode  out  1  engine mode (1 = RX, 0 = TX).
- eng_transmit_data  out  W  engine transmit word.
- eng_busy  in  1  engine busy.
- eng_finish  in  1  engine finish strobe; counted for status only.
- eng_receive_data  in  W  engine received word.
- finish_cnt  out  8  number of eng_finish high cycles seen in the current or last transfer.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs 0: eng_start, eng_mode, eng_transmit_data, tx_ack, rx_ack, rx_rdata, err, last_mode, finish_cnt.
  - Round-robin pointer favours RX.
- States: IDLE, ISSUE, WAIT_BUSY, RUN, DONE, ERR.
- IDLE:
  - If exactly one request is pending, grant it.
  - If both are pending, grant the side the pointer favours, then flip the pointer to the other side.
  - On grant: latch tx_wdata into eng_transmit_data (TX grants only), set last_mode, clear finish_cnt, go to ISSUE.
  - A request seen in IDLE is granted on the next edge: one cycle from request to ISSUE.
- ISSUE:
  - eng_start=1 and eng_mode=last_mode for exactly START_HOLD cycles.
  - After START_HOLD cycles, drive eng_start=0 and eng_mode=0, then go to WAIT_BUSY.
- WAIT_BUSY:
  - When eng_busy=1, go to RUN.
  - If the timeout counter reaches TIMEOUT, go to ERR.
  - The counter resets on entry to each state.
- RUN:
  - Increment finish_cnt (saturating at 255) each cycle eng_finish=1.
  - When eng_busy=0, go to DONE.
  - If TIMEOUT is reached, go to ERR.
- DONE (one cycle):
  - RX: rx_rdata <= eng_receive_data, pulse rx_ack.
  - TX: pulse tx_ack.
  - Go to IDLE.
  - The requester must drop its request in the cycle after ack; a request still high in the next IDLE cycle is a new request.
- ERR:
  - Set err=1 and pulse the granted side's ack once; rx_rdata is not updated.
  - Hold eng_start=0 and stay in ERR until err_clr=1, then go to IDLE.
- Stability: eng_transmit_data stays stable from grant until the next TX grant.
- Ignored inputs:
  - Requests outside IDLE are ignored and remain pending.
  - eng_busy in IDLE/ISSUE is ignored.
- err_clr in any state other than ERR clears err only.
- Reset mid-transfer: immediate return to IDLE with all outputs 0. The engine is not otherwise aborted.

Test Plan:
- RX only: rx_req=1; engine model busy for 40 cycles returning 32'd1_456_478_547 → eng_start high 2 cycles with eng_mode=1; rx_ack a single pulse; rx_rdata=32'd1_456_478_547; err=0.
- TX only: tx_wdata=32'hA5A5_0F0F, tx_req=1 → eng_mode=0 during start; eng_transmit_data=32'hA5A5_0F0F; tx_ack a single pulse; model's 5 finish cycles give finish_cnt=5.
- Both requesters held high continuously for 4 transfers → grant order RX, TX, RX, TX; never two consecutive grants to the same side.
- Engine never asserts busy with TIMEOUT=15 → ERR entered 15 cycles after ISSUE exits; err=1; one tx_ack/rx_ack pulse; no further eng_start until err_clr, after which the pending request is served.
- rst pulsed while in RUN → all outputs 0 asynchronously; after release, a held request is re-granted with a fresh START_HOLD start pulse.
- START_HOLD=1, back-to-back TX requests (tx_req held) → two separate start pulses, each preceded by an IDLE cycle; two tx_ack pulses.
